// File: rtl/hazard_controller.sv
// Hazard sequencer for the 5-stage MIPS pipeline: covers load-use, branch-in-ID,
// HI/LO-while-busy and memory wait dependencies, plus a stall-cycle counter.
module hazard_controller #(
   parameter int MD_LATENCY = 32,
   parameter int CNT_W      = 6
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic [4:0]  iID_NumRs,
   input  logic [4:0]  iID_NumRt,
   input  logic        iID_UsesRs,
   input  logic        iID_UsesRt,
   input  logic        iID_Branch,
   input  logic        iID_BranchTaken,
   input  logic        iID_HiLoAccess,
   input  logic [4:0]  iEX_NumRd,
   input  logic        iEX_RegWrite,
   input  logic        iEX_MemRead,
   input  logic        iEX_MDStart,
   input  logic [4:0]  iMEM_NumRd,
   input  logic        iMEM_MemRead,
   input  logic        iMemWait,
   output logic        oPCWrite,
   output logic        oIFIDWrite,
   output logic        oIDEXWrite,
   output logic        oEXMEMWrite,
   output logic        oMEMWBWrite,
   output logic        oIFIDFlush,
   output logic        oIDEXFlush,
   output logic        oMDBusy,
   output logic [31:0] oStallCycles
);

   typedef enum logic [0:0] {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;

   localparam logic [CNT_W-1:0] MD_LAT_C = CNT_W'(MD_LATENCY);

   md_state_t        state_r, state_nxt_s;
   logic [CNT_W-1:0] mdcnt_r, mdcnt_nxt_s;
   logic [31:0]      stall_cnt_r;
   logic             load_use_s, br_ex_s, br_mem_s, md_haz_s, stall_s;

   // A producer register only matters if it is non-zero and actually read in ID.
   function automatic logic src_match(input logic [4:0] dst, input logic [4:0] src,
                                      input logic uses);
      return uses && (src != 5'd0) && (dst == src);
   endfunction

   // Hazard detection terms.
   always_comb begin
      load_use_s = iEX_MemRead &&
                   (src_match(iEX_NumRd, iID_NumRs, iID_UsesRs) ||
                    src_match(iEX_NumRd, iID_NumRt, iID_UsesRt));
      br_ex_s    = iID_Branch && iEX_RegWrite &&
                   (src_match(iEX_NumRd, iID_NumRs, iID_UsesRs) ||
                    src_match(iEX_NumRd, iID_NumRt, iID_UsesRt));
      br_mem_s   = iID_Branch && iMEM_MemRead &&
                   (src_match(iMEM_NumRd, iID_NumRs, iID_UsesRs) ||
                    src_match(iMEM_NumRd, iID_NumRt, iID_UsesRt));
      md_haz_s   = (state_r == MD_BUSY) && iID_HiLoAccess;
      stall_s    = load_use_s || br_ex_s || br_mem_s || md_haz_s;
   end

   // Pipeline controls: reset forces run values, then freeze > stall > flush.
   always_comb begin
      oPCWrite    = 1'b1;
      oIFIDWrite  = 1'b1;
      oIDEXWrite  = 1'b1;
      oEXMEMWrite = 1'b1;
      oMEMWBWrite = 1'b1;
      oIFIDFlush  = 1'b0;
      oIDEXFlush  = 1'b0;
      if (iRST) begin
         oPCWrite = 1'b1;
      end else if (iMemWait) begin
         oPCWrite    = 1'b0;
         oIFIDWrite  = 1'b0;
         oIDEXWrite  = 1'b0;
         oEXMEMWrite = 1'b0;
         oMEMWBWrite = 1'b0;
      end else if (stall_s) begin
         oPCWrite   = 1'b0;
         oIFIDWrite = 1'b0;
         oIDEXFlush = 1'b1;
      end else if (iID_BranchTaken) begin
         oIFIDFlush = 1'b1;
      end else begin
         oIFIDFlush = 1'b0;
      end
   end

   // Mult/div busy tracker; runs through memory waits since the unit is independent.
   always_comb begin
      state_nxt_s = state_r;
      mdcnt_nxt_s = mdcnt_r;
      case (state_r)
         MD_IDLE: begin
            if (iEX_MDStart && !iMemWait) begin
               state_nxt_s = MD_BUSY;
               mdcnt_nxt_s = MD_LAT_C;
            end else begin
               state_nxt_s = MD_IDLE;
            end
         end
         MD_BUSY: begin
            if (iEX_MDStart) begin
               mdcnt_nxt_s = MD_LAT_C;
            end else if (mdcnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
               state_nxt_s = MD_IDLE;
               mdcnt_nxt_s = {CNT_W{1'b0}};
            end else begin
               mdcnt_nxt_s = mdcnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_nxt_s = MD_IDLE;
            mdcnt_nxt_s = {CNT_W{1'b0}};
         end
      endcase
   end

   // State, mult/div counter and stall-cycle counter registers.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_r     <= MD_IDLE;
         mdcnt_r     <= {CNT_W{1'b0}};
         stall_cnt_r <= 32'd0;
      end else begin
         state_r <= state_nxt_s;
         mdcnt_r <= mdcnt_nxt_s;
         if (!oPCWrite) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end

   assign oMDBusy      = (state_r == MD_BUSY);
   assign oStallCycles = stall_cnt_r;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: per-cycle expectations queued from a
// behavioural model, plus directed checks of the stall counter.
module tb_hazard_controller;

   localparam int LAT = 4;

   logic        iCLK, iRST;
   logic [4:0]  iID_NumRs, iID_NumRt, iEX_NumRd, iMEM_NumRd;
   logic        iID_UsesRs, iID_UsesRt, iID_Branch, iID_BranchTaken, iID_HiLoAccess;
   logic        iEX_RegWrite, iEX_MemRead, iEX_MDStart, iMEM_MemRead, iMemWait;
   logic        oPCWrite, oIFIDWrite, oIDEXWrite, oEXMEMWrite, oMEMWBWrite;
   logic        oIFIDFlush, oIDEXFlush, oMDBusy;
   logic [31:0] oStallCycles;

   hazard_controller #(.MD_LATENCY(LAT), .CNT_W(6)) dut (
      .iCLK(iCLK), .iRST(iRST),
      .iID_NumRs(iID_NumRs), .iID_NumRt(iID_NumRt),
      .iID_UsesRs(iID_UsesRs), .iID_UsesRt(iID_UsesRt),
      .iID_Branch(iID_Branch), .iID_BranchTaken(iID_BranchTaken),
      .iID_HiLoAccess(iID_HiLoAccess),
      .iEX_NumRd(iEX_NumRd), .iEX_RegWrite(iEX_RegWrite),
      .iEX_MemRead(iEX_MemRead), .iEX_MDStart(iEX_MDStart),
      .iMEM_NumRd(iMEM_NumRd), .iMEM_MemRead(iMEM_MemRead),
      .iMemWait(iMemWait),
      .oPCWrite(oPCWrite), .oIFIDWrite(oIFIDWrite), .oIDEXWrite(oIDEXWrite),
      .oEXMEMWrite(oEXMEMWrite), .oMEMWBWrite(oMEMWBWrite),
      .oIFIDFlush(oIFIDFlush), .oIDEXFlush(oIDEXFlush),
      .oMDBusy(oMDBusy), .oStallCycles(oStallCycles)
   );

   typedef struct {
      logic [7:0]  ctl;
      logic [31:0] cnt;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          md_left  = 0;
   int unsigned cnt_m    = 0;

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit hit(input logic [4:0] dst, input logic [4:0] src, input logic uses);
      return uses && (src != 5'd0) && (dst == src);
   endfunction

   task automatic clr();
      iID_NumRs = 5'd0; iID_NumRt = 5'd0; iID_UsesRs = 1'b0; iID_UsesRt = 1'b0;
      iID_Branch = 1'b0; iID_BranchTaken = 1'b0; iID_HiLoAccess = 1'b0;
      iEX_NumRd = 5'd0; iEX_RegWrite = 1'b0; iEX_MemRead = 1'b0; iEX_MDStart = 1'b0;
      iMEM_NumRd = 5'd0; iMEM_MemRead = 1'b0; iMemWait = 1'b0;
   endtask

   // Push the expectation for the current inputs, compare mid-cycle, advance the model.
   task automatic cycle(input string tag);
      bit         ex_src, mem_src, stl;
      logic [6:0] pipe;
      exp_t       e, got;
      ex_src  = hit(iEX_NumRd, iID_NumRs, iID_UsesRs) || hit(iEX_NumRd, iID_NumRt, iID_UsesRt);
      mem_src = hit(iMEM_NumRd, iID_NumRs, iID_UsesRs) || hit(iMEM_NumRd, iID_NumRt, iID_UsesRt);
      stl = (iEX_MemRead && ex_src) || (iID_Branch && iEX_RegWrite && ex_src) ||
            (iID_Branch && iMEM_MemRead && mem_src) || ((md_left != 0) && iID_HiLoAccess);
      if (iRST)                 pipe = 7'b11111_00;
      else if (iMemWait)        pipe = 7'b00000_00;
      else if (stl)             pipe = 7'b00111_01;
      else if (iID_BranchTaken) pipe = 7'b11111_10;
      else                      pipe = 7'b11111_00;
      e.ctl = {pipe, (md_left != 0)};
      e.cnt = cnt_m;
      sb_q.push_back(e);
      @(negedge iCLK);
      got = sb_q.pop_front();
      check_val({tag, "_ctl"},
                {24'd0, oPCWrite, oIFIDWrite, oIDEXWrite, oEXMEMWrite, oMEMWBWrite,
                 oIFIDFlush, oIDEXFlush, oMDBusy}, {24'd0, got.ctl});
      check_val({tag, "_cnt"}, oStallCycles, got.cnt);
      @(posedge iCLK);
      if (iRST) begin
         md_left = 0;
         cnt_m   = 0;
      end else begin
         if (!pipe[6]) cnt_m++;
         if (iEX_MDStart && ((md_left != 0) || !iMemWait)) md_left = LAT;
         else if (md_left != 0) md_left--;
      end
      #1;
   endtask

   initial begin
      clr();
      iRST = 1'b1;
      @(posedge iCLK);
      #1;
      cycle("reset0");
      cycle("reset1");
      iRST = 1'b0;
      cycle("idle");

      // load-use: lw $t0 in EX, add reading $t0 in ID
      iEX_NumRd = 5'd8; iEX_MemRead = 1'b1; iEX_RegWrite = 1'b1;
      iID_NumRs = 5'd8; iID_UsesRs = 1'b1;
      cycle("loaduse");
      check_val("loaduse_cnt_now", oStallCycles, 32'd1);
      clr(); iMEM_NumRd = 5'd8; iMEM_MemRead = 1'b1; iID_NumRs = 5'd8; iID_UsesRs = 1'b1;
      cycle("loaduse_release");

      // reads of $zero or unused rt never match
      clr(); iEX_NumRd = 5'd0; iEX_MemRead = 1'b1; iID_NumRs = 5'd0; iID_UsesRs = 1'b1;
      cycle("zero_reg");
      clr(); iEX_NumRd = 5'd8; iEX_MemRead = 1'b1; iID_NumRt = 5'd8; iID_UsesRt = 1'b0;
      cycle("rt_unused");

      // branch after load: two stall cycles then the taken flush
      clr(); iID_Branch = 1'b1; iID_BranchTaken = 1'b1; iID_NumRs = 5'd8; iID_UsesRs = 1'b1;
      iEX_NumRd = 5'd8; iEX_MemRead = 1'b1; iEX_RegWrite = 1'b1;
      cycle("br_ex");
      iEX_NumRd = 5'd0; iEX_MemRead = 1'b0; iEX_RegWrite = 1'b0;
      iMEM_NumRd = 5'd8; iMEM_MemRead = 1'b1;
      cycle("br_mem");
      iMEM_NumRd = 5'd0; iMEM_MemRead = 1'b0;
      cycle("br_flush");
      check_val("branch_cnt_now", oStallCycles, 32'd3);

      // mult/div: start, then mfhi waits out LAT busy cycles
      clr(); iEX_MDStart = 1'b1;
      cycle("md_start");
      clr(); iID_HiLoAccess = 1'b1;
      for (int i = 0; i < LAT; i++) cycle("md_wait");
      cycle("md_release");
      check_val("md_cnt_now", oStallCycles, 32'd7);

      // freeze beats stall and flush, still counted as a stall cycle
      clr(); iMemWait = 1'b1; iID_BranchTaken = 1'b1;
      iEX_NumRd = 5'd8; iEX_MemRead = 1'b1; iID_NumRs = 5'd8; iID_UsesRs = 1'b1;
      cycle("freeze");
      check_val("freeze_cnt_now", oStallCycles, 32'd8);

      // randomised traffic on a small register set
      for (int i = 0; i < 300; i++) begin
         iRST            = ($urandom_range(0, 49) == 0);
         iID_NumRs       = 5'($urandom_range(0, 3));
         iID_NumRt       = 5'($urandom_range(0, 3));
         iID_UsesRs      = 1'($urandom_range(0, 1));
         iID_UsesRt      = 1'($urandom_range(0, 1));
         iID_Branch      = ($urandom_range(0, 3) == 0);
         iID_BranchTaken = 1'($urandom_range(0, 1));
         iID_HiLoAccess  = ($urandom_range(0, 2) == 0);
         iEX_NumRd       = 5'($urandom_range(0, 3));
         iEX_RegWrite    = 1'($urandom_range(0, 1));
         iEX_MemRead     = ($urandom_range(0, 2) == 0);
         iEX_MDStart     = (md_left == 0) && ($urandom_range(0, 7) == 0);
         iMEM_NumRd      = 5'($urandom_range(0, 3));
         iMEM_MemRead    = ($urandom_range(0, 2) == 0);
         iMemWait        = ($urandom_range(0, 7) == 0);
         cycle("rand");
      end

      // reset while busy with three cycles left
      clr(); iRST = 1'b0; iEX_MDStart = 1'b1;
      cycle("rstbusy_start");
      clr();
      cycle("rstbusy_run");
      iRST = 1'b1;
      cycle("rstbusy_rst");
      check_val("rstbusy_busy", {31'd0, oMDBusy}, 32'd0);
      check_val("rstbusy_cnt", oStallCycles, 32'd0);
      iRST = 1'b0; iID_HiLoAccess = 1'b1;
      cycle("rstbusy_after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard sequencer for the 5-stage MIPS core. It sits beside the forwarding unit and covers every dependency that forwarding cannot resolve:

- load-use hazards;
- branch operands not yet available in ID;
- HI/LO accesses while the multicycle mult/div unit is busy;
- external memory wait states.

It drives the stage-register enables and bubble/flush controls, and keeps a free-running stall-cycle counter for performance debugging.

## Interface
Parameters:
- MD_LATENCY, 32, cycles the mult/div unit is busy after a start (legal range ≥1)
- CNT_W, 6, mult/div counter width (must hold MD_LATENCY)

Ports:
- iCLK  in  1  clock; all state updates on the rising edge
- iRST  in  1  reset, synchronous, active-high
- iID_NumRs / iID_NumRt  in  5  source registers of the instruction in ID
- iID_UsesRs / iID_UsesRt  in  1  ID instruction actually reads rs / rt
- iID_Branch  in  1  ID instruction resolves in ID (beq/bne/jr), so it needs its operands in ID
- iID_BranchTaken  in  1  branch/jump in ID is taken
- iID_HiLoAccess  in  1  ID instruction is mfhi/mflo/mthi/mtlo/mult/div
- iEX_NumRd  in  5  destination register of the instruction in EX
- iEX_RegWrite / iEX_MemRead  in  1  EX instruction writes the register file / is a load
- iEX_MDStart  in  1  mult/div in EX starts the unit this cycle
- iMEM_NumRd  in  5  destination register of the instruction in MEM
- iMEM_MemRead  in  1  MEM instruction is a load
- iMemWait  in  1  instruction/data memory not ready; freeze the whole pipeline
- oPCWrite, oIFIDWrite  out  1  PC and IF/ID register enables
- oIDEXWrite, oEXMEMWrite, oMEMWBWrite  out  1  downstream stage register enables
- oIFIDFlush  out  1  zero the IF/ID register (squash the fetched instruction)
- oIDEXFlush  out  1  load a bubble (nop) into ID/EX
- oMDBusy  out  1  mult/div unit busy
- oStallCycles  out  32  count of cycles with oPCWrite low

## Operation
Hazard terms are evaluated combinationally every cycle. A register "matches" only if its number is non-zero and the corresponding Uses bit is set.
- LoadUse: iEX_MemRead and iEX_NumRd matches ID rs or rt.
- BrEX: iID_Branch, iEX_RegWrite, and iEX_NumRd matches ID rs/rt.
- BrMEM: iID_Branch, iMEM_MemRead, and iMEM_NumRd matches ID rs/rt.
- MDHaz: state BUSY and iID_HiLoAccess.
- Stall = LoadUse | BrEX | BrMEM | MDHaz.

Output priority is freeze, then stall, then flush:
- Freeze (iMemWait=1): all five enables are 0; both flushes are 0.
- Stall (no freeze): oPCWrite=0, oIFIDWrite=0, oIDEXFlush=1; the remaining enables are 1; oIFIDFlush=0.
- Flush (no freeze, no stall, iID_BranchTaken=1): oIFIDFlush=1; all enables are 1.
- Otherwise: all enables are 1, both flushes are 0.

Mult/div FSM:
- States: IDLE, BUSY. Register mdcnt is CNT_W bits wide.
- IDLE → BUSY when iEX_MDStart=1 and iMemWait=0; mdcnt loads MD_LATENCY.
- In BUSY, each edge: if mdcnt==1, go to IDLE and set mdcnt=0; otherwise decrement mdcnt.
- The counter keeps decrementing during iMemWait, because the unit runs independently of the pipeline.
- iEX_MDStart in BUSY is a restart: mdcnt reloads to MD_LATENCY and the state stays BUSY. This cannot occur in legal operation because MDHaz stalls such instructions.
- oMDBusy = (state==BUSY).

oStallCycles increments by 1, wrapping modulo 2^32, on every edge where oPCWrite=0.

Reset (iRST=1 at an edge): state goes to IDLE, mdcnt=0, oStallCycles=0. This applies mid-BUSY as well; the pipeline is flushed by the core's own reset. While iRST is high, all combinational outputs are forced to run values: enables=1, flushes=0. oMDBusy then reads 0 from the next cycle on.

## Timing
- Stall/flush/enable outputs are purely combinational from inputs and state; there is no added latency.
- LoadUse, BrEX, and BrMEM each stall for exactly 1 cycle per occurrence, because the producer advances.
- A branch depending on a load in EX therefore stalls 2 cycles: LoadUse/BrEX, then BrMEM.
- Mult/div with iEX_MDStart in cycle T:
  - oMDBusy is high in cycles T+1..T+MD_LATENCY.
  - A HI/LO reader in ID is stalled through T+MD_LATENCY and proceeds at T+MD_LATENCY+1.
- With MD_LATENCY=1, busy lasts exactly cycle T+1.
- oStallCycles reflects a stall cycle on the edge ending that cycle.
- Simultaneous stall and taken branch: the stall wins and there is no flush; the branch re-evaluates the next cycle.

## Test plan
- Load-use: EX lw $t0 (NumRd=8, MemRead=1), ID add reading rs=8 → oPCWrite=0, oIFIDWrite=0, oIDEXFlush=1 for 1 cycle; oStallCycles goes 0→1.
- Same as load-use but ID reads $zero, or UsesRt=0 with rt=8 → no stall; all enables 1.
- Branch after load: ID beq rs=8 with lw $t0 in EX, then in MEM → 2 consecutive stall cycles, then oIFIDFlush=1 when iID_BranchTaken=1.
- Mult/div: MD_LATENCY=4, iEX_MDStart at cycle 10, mfhi in ID from cycle 11 → oMDBusy high cycles 11–14, stall 11–14, release at 15; oStallCycles=4.
- Freeze versus stall: iMemWait=1 concurrent with LoadUse and iID_BranchTaken → all enables 0, both flushes 0; oStallCycles still increments.
- Reset mid-BUSY: iRST=1 at mdcnt=3 → next cycle oMDBusy=0, oStallCycles=0, all enables 1.
